ibex_trace_arbiter: RTL and testbench
=====================================

# ibex_trace_arbiter

Merges the fetch (IF) and execute (IDEX) trace event streams of the Ibex microarchitecture tracer into a single valid/ready trace output port, for hardware trace capture without DPI. Each source has its own small FIFO. A round-robin arbiter drains both FIFOs into a registered output stage. Events that cannot be queued are counted in a saturating drop counter. It sits between the core's trace taps and the trace sink (DMA/UART packetizer).

## Interface
Parameters:
- DEPTH, 4, entries per source FIFO; power of two, ≥2
- DROP_W, 8, width of drop counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- trace_en  in  1  accept new events when high
- if_evt_valid  in  1  one-cycle fetch event strobe
- if_evt_type  in  2  0 single fetch, 1 fetch start, 2 fetch end; 3 reserved
- if_evt_pc  in  32  fetch PC
- if_evt_insn  in  32  fetched instruction (expanded)
- ex_evt_valid  in  1  one-cycle execute event strobe
- ex_evt_type  in  2  0 single-cycle, 1 multicycle start, 2 multicycle end; 3 reserved
- ex_evt_pc  in  32  executing PC
- out_valid  out  1  output event available
- out_ready  in  1  sink accepts the event
- out_src  out  1  0 = IF, 1 = IDEX
- out_type  out  2  event type, copied from the source
- out_pc  out  32  event PC
- out_insn  out  32  instruction word; 0 for IDEX events
- out_drops  out  DROP_W  saturating count of dropped events
- drop_clr  in  1  synchronous clear of out_drops
- if_full, ex_full  out  1 each  per-source FIFO full flag

## Operation
- Reset: both FIFOs empty, out_valid=0, out_src/out_type/out_pc/out_insn=0, out_drops=0, round-robin pointer favours IF, if_full=ex_full=0.
- Push:
  - An event is pushed into its source FIFO when evt_valid=1 and trace_en=1.
  - When trace_en=0, the event is ignored and not counted as a drop.
  - Reserved type 3 is pushed unchanged.
- Full handling:
  - A push to a full FIFO is dropped, and out_drops increments, saturating at 2^DROP_W−1.
  - Exception: if that same FIFO is popped in the same cycle, the push is accepted and nothing is dropped.
  - If both sources drop in the same cycle, out_drops increments by 2, still saturating.
- drop_clr: out_drops is cleared to 0. If drops occur in the same cycle, out_drops is set to the number of drops in that cycle (1 or 2).
- Output stage: a single register that loads when it is empty (out_valid=0) or its event is consumed (out_valid & out_ready).
- Arbitration at each load:
  - If only one FIFO is non-empty, pop that FIFO.
  - If both are non-empty, pop the source not granted last.
  - The pointer updates only when a load happens.
- Stability: while out_valid=1 and out_ready=0, all out_* fields are held stable.
- Per-source ordering is preserved. Cross-source order is arbitration order, not timestamp order.
- Pointers: the FIFO read/write pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.
- Draining: queued events keep draining while trace_en=0.

## Timing
- Latency: an event strobed in cycle 0 into an empty FIFO with an empty output register appears with out_valid=1 in cycle 2.
- Throughput: one event per cycle while out_ready=1.
- Sustained load: both sources strobing every cycle exceeds throughput, so drops are expected once the FIFOs fill.
- Capacity per source with the sink stalled: DEPTH queued, plus 1 in the output register for whichever source won.
- if_full/ex_full are registered status, valid in the cycle after the push that fills the FIFO.
- Reset assertion mid-operation empties everything immediately, with no output handshake completion. First acceptance is in the cycle after rst_n deasserts.

## Test plan
- Single event:
  - Stimulus: IF strobe in cycle 0 (type 0, pc=0x80, insn=0x00000013), out_ready=1.
  - Required: cycle 2 out_valid=1, src=0, pc=0x80, insn=0x13; cycle 3 out_valid=0.
- Simultaneous sources:
  - Stimulus: IF (pc=0x100) and EX (pc=0x0FC) strobed together from reset, out_ready=1.
  - Required: IF emitted in cycle 2, EX in cycle 3.
  - Stimulus: repeat the same strobe.
  - Required: EX emitted first, since the pointer alternates.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with an event pending.
  - Required: out_valid=1 with all fields constant; the event is consumed exactly once when out_ready=1.
- Overflow:
  - Stimulus: DEPTH=4, out_ready=0, 7 consecutive IF strobes.
  - Required: if_full=1, out_drops=2.
  - Stimulus: release out_ready.
  - Required: exactly 5 events output in push order (the first five pc values).
- Drop counter:
  - Stimulus: DROP_W=2, force 5 drops.
  - Required: out_drops=3 (saturated).
  - Stimulus: drop_clr together with one drop.
  - Required: out_drops=1.
- Enable and reset:
  - Stimulus: trace_en=0 with strobes.
  - Required: no output and out_drops unchanged.
  - Stimulus: rst_n low while out_valid=1 and the FIFOs are non-empty.
  - Required: out_valid=0 and the FIFOs empty immediately.

Source files
------------

// File: rtl/ibex_trace_arbiter.sv
// Merges IF and IDEX trace events into one valid/ready stream via per-source FIFOs and round-robin.
// Latency: 2 cycles from strobe to out_valid; 1 event/cycle throughput.
// Backpressure: out_* held while out_valid & !out_ready; full-FIFO pushes are dropped and counted.
module ibex_trace_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    // Extra pointer bit tells full (bits differ) from empty (bits equal)
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_dat = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end
endmodule

module ibex_trace_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trace_en,
    input  logic              if_evt_valid,
    input  logic [1:0]        if_evt_type,
    input  logic [31:0]       if_evt_pc,
    input  logic [31:0]       if_evt_insn,
    input  logic              ex_evt_valid,
    input  logic [1:0]        ex_evt_type,
    input  logic [31:0]       ex_evt_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_src,
    output logic [1:0]        out_type,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_insn,
    output logic [DROP_W-1:0] out_drops,
    input  logic              drop_clr,
    output logic              if_full,
    output logic              ex_full
);
    logic        if_push, ex_push, if_pop, ex_pop, if_empty, ex_empty;
    logic        if_drop, ex_drop, load_en, fav_ex;
    logic [65:0] if_rd_dat;
    logic [33:0] ex_rd_dat;
    logic [1:0]  n_drop;
    logic [DROP_W-1:0] drop_base;
    logic [DROP_W:0]   drop_sum;

    ibex_trace_fifo #(.DEPTH(DEPTH), .W(66)) u_if_fifo (
        .clk(clk), .rst_n(rst_n), .push(if_push),
        .push_dat({if_evt_type, if_evt_pc, if_evt_insn}),
        .pop(if_pop), .pop_dat(if_rd_dat), .empty(if_empty), .full(if_full)
    );

    ibex_trace_fifo #(.DEPTH(DEPTH), .W(34)) u_ex_fifo (
        .clk(clk), .rst_n(rst_n), .push(ex_push),
        .push_dat({ex_evt_type, ex_evt_pc}),
        .pop(ex_pop), .pop_dat(ex_rd_dat), .empty(ex_empty), .full(ex_full)
    );

    assign load_en = !out_valid || out_ready;

    always_comb begin
        if_pop = 1'b0;
        ex_pop = 1'b0;
        if (load_en) begin
            if (!if_empty && !ex_empty) begin
                if_pop = !fav_ex;
                ex_pop = fav_ex;
            end else begin
                if_pop = !if_empty;
                ex_pop = !ex_empty;
            end
        end
    end

    // A pop of the same FIFO frees a slot for this cycle's push
    assign if_push = trace_en && if_evt_valid && (!if_full || if_pop);
    assign ex_push = trace_en && ex_evt_valid && (!ex_full || ex_pop);
    assign if_drop = trace_en && if_evt_valid && if_full && !if_pop;
    assign ex_drop = trace_en && ex_evt_valid && ex_full && !ex_pop;

    assign n_drop    = {1'b0, if_drop} + {1'b0, ex_drop};
    assign drop_base = drop_clr ? '0 : out_drops;
    assign drop_sum  = {1'b0, drop_base} + (DROP_W+1)'(n_drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_src   <= 1'b0;
            out_type  <= 2'd0;
            out_pc    <= 32'd0;
            out_insn  <= 32'd0;
            out_drops <= '0;
            fav_ex    <= 1'b0;
        end else begin
            out_drops <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            if (load_en) begin
                out_valid <= if_pop || ex_pop;
                if (if_pop) begin
                    out_src  <= 1'b0;
                    out_type <= if_rd_dat[65:64];
                    out_pc   <= if_rd_dat[63:32];
                    out_insn <= if_rd_dat[31:0];
                end else if (ex_pop) begin
                    out_src  <= 1'b1;
                    out_type <= ex_rd_dat[33:32];
                    out_pc   <= ex_rd_dat[31:0];
                    out_insn <= 32'd0;
                end
            end
            // Turn passes only on contended loads so a lone source never costs the other its turn
            if (if_pop && !ex_empty)      fav_ex <= 1'b1;
            else if (ex_pop && !if_empty) fav_ex <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ibex_trace_arbiter.sv
module tb_ibex_trace_arbiter;
    localparam int DEPTH = 4;
    localparam int DROP_W = 2;
    localparam int DMAX = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic trace_en = 1'b1;
    logic if_evt_valid = 1'b0;
    logic [1:0] if_evt_type = 2'd0;
    logic [31:0] if_evt_pc = 32'd0;
    logic [31:0] if_evt_insn = 32'd0;
    logic ex_evt_valid = 1'b0;
    logic [1:0] ex_evt_type = 2'd0;
    logic [31:0] ex_evt_pc = 32'd0;
    logic out_valid, out_src, if_full, ex_full;
    logic out_ready = 1'b1;
    logic [1:0] out_type;
    logic [31:0] out_pc, out_insn;
    logic [DROP_W-1:0] out_drops;
    logic drop_clr = 1'b0;

    always #5 clk = ~clk;

    ibex_trace_arbiter #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst_n(rst_n), .trace_en(trace_en),
        .if_evt_valid(if_evt_valid), .if_evt_type(if_evt_type),
        .if_evt_pc(if_evt_pc), .if_evt_insn(if_evt_insn),
        .ex_evt_valid(ex_evt_valid), .ex_evt_type(ex_evt_type), .ex_evt_pc(ex_evt_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
        .out_type(out_type), .out_pc(out_pc), .out_insn(out_insn),
        .out_drops(out_drops), .drop_clr(drop_clr), .if_full(if_full), .ex_full(ex_full)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: queues per source, one output slot, contention turn, drop count
    typedef struct packed {
        logic        src;
        logic [1:0]  typ;
        logic [31:0] pc;
        logic [31:0] insn;
    } ev_t;

    ev_t qi[$];
    ev_t qe[$];
    ev_t m_out;
    bit  m_vld;
    bit  m_fav_ex;
    int  m_drops;
    bit  take_if, take_ex;
    int  nd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qi.delete();
            qe.delete();
            m_vld = 0;
            m_out = '0;
            m_fav_ex = 0;
            m_drops = 0;
        end else begin
            take_if = 0;
            take_ex = 0;
            if (!m_vld || out_ready) begin
                if (qi.size() > 0 && qe.size() > 0) begin
                    if (m_fav_ex) take_ex = 1; else take_if = 1;
                    m_fav_ex = take_if;
                end else if (qi.size() > 0) take_if = 1;
                else if (qe.size() > 0) take_ex = 1;
                m_vld = take_if || take_ex;
                if (take_if) m_out = qi.pop_front();
                if (take_ex) m_out = qe.pop_front();
            end
            nd = 0;
            if (trace_en && if_evt_valid) begin
                if (qi.size() < DEPTH) qi.push_back({1'b0, if_evt_type, if_evt_pc, if_evt_insn});
                else nd++;
            end
            if (trace_en && ex_evt_valid) begin
                if (qe.size() < DEPTH) qe.push_back({1'b1, ex_evt_type, ex_evt_pc, 32'd0});
                else nd++;
            end
            if (drop_clr) m_drops = nd;
            else m_drops = (m_drops + nd > DMAX) ? DMAX : m_drops + nd;
        end
    end

    always @(negedge clk) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
        if (m_vld) begin
            chk("out_src", {31'd0, out_src}, {31'd0, m_out.src});
            chk("out_type", {30'd0, out_type}, {30'd0, m_out.typ});
            chk("out_pc", out_pc, m_out.pc);
            chk("out_insn", out_insn, m_out.insn);
        end
        chk("out_drops", 32'(out_drops), 32'(m_drops));
        chk("if_full", {31'd0, if_full}, {31'd0, qi.size() == DEPTH});
        chk("ex_full", {31'd0, ex_full}, {31'd0, qe.size() == DEPTH});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_if(input logic [31:0] pc, input logic [31:0] insn);
        if_evt_valid = 1'b1;
        if_evt_type = 2'd0;
        if_evt_pc = pc;
        if_evt_insn = insn;
    endtask

    task automatic strobe_ex(input logic [31:0] pc);
        ex_evt_valid = 1'b1;
        ex_evt_type = 2'd0;
        ex_evt_pc = pc;
    endtask

    task automatic idle();
        if_evt_valid = 1'b0;
        ex_evt_valid = 1'b0;
    endtask

    logic [31:0] got[$];
    logic [31:0] held_pc;

    initial begin
        tick();
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_drops", 32'(out_drops), 32'd0);
        rst_n = 1'b1;
        tick();

        // single event
        strobe_if(32'h80, 32'h13);
        tick(); idle();
        tick();
        chk("single_vld_c2", {31'd0, out_valid}, 32'd1);
        chk("single_src", {31'd0, out_src}, 32'd0);
        chk("single_pc", out_pc, 32'h80);
        chk("single_insn", out_insn, 32'h13);
        tick();
        chk("single_vld_c3", {31'd0, out_valid}, 32'd0);

        // simultaneous sources, twice
        strobe_if(32'h100, 32'h00100093); strobe_ex(32'hFC);
        tick(); idle();
        tick();
        chk("sim1_first_pc", out_pc, 32'h100);
        tick();
        chk("sim1_second_pc", out_pc, 32'hFC);
        chk("sim1_second_insn", out_insn, 32'd0);
        tick();
        strobe_if(32'h100, 32'h00100093); strobe_ex(32'hFC);
        tick(); idle();
        tick();
        chk("sim2_first_src", {31'd0, out_src}, 32'd1);
        tick();
        chk("sim2_second_src", {31'd0, out_src}, 32'd0);
        tick();

        // backpressure
        out_ready = 1'b0;
        strobe_ex(32'h200); ex_evt_type = 2'd1;
        tick(); idle();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", {31'd0, out_valid}, 32'd1);
            chk("bp_pc", out_pc, 32'h200);
            chk("bp_type", {30'd0, out_type}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_consumed_once", {31'd0, out_valid}, 32'd0);

        // overflow
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            strobe_if(32'h1000 + 32'(4 * i), 32'(i));
            tick();
        end
        idle();
        tick();
        chk("ovf_if_full", {31'd0, if_full}, 32'd1);
        chk("ovf_drops", 32'(out_drops), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) got.push_back(out_pc);
            tick();
        end
        chk("ovf_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            held_pc = (i < got.size()) ? got[i] : 32'hDEAD;
            chk("ovf_order", held_pc, 32'h1000 + 32'(4 * i));
        end

        // drop counter saturation and clear
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        chk("clr_drops", 32'(out_drops), 32'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            strobe_if(32'h2000 + 32'(4 * i), 32'd0);
            tick();
        end
        idle();
        tick();
        chk("sat_drops", 32'(out_drops), 32'd3);
        drop_clr = 1'b1;
        strobe_if(32'h3000, 32'd0);
        tick();
        drop_clr = 1'b0; idle();
        chk("clr_with_drop", 32'(out_drops), 32'd1);

        // enable gating
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        trace_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strobe_if(32'h4000, 32'd0); strobe_ex(32'h4004);
            tick();
            chk("en_off_vld", {31'd0, out_valid}, 32'd0);
            chk("en_off_drops", 32'(out_drops), 32'd1);
        end
        idle();
        trace_en = 1'b1;

        // async reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe_if(32'h5000 + 32'(4 * i), 32'd0); strobe_ex(32'h6000 + 32'(4 * i));
            tick();
        end
        idle();
        tick();
        chk("pre_rst_vld", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_pc", out_pc, 32'd0);
        chk("rst_mid_drops", 32'(out_drops), 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
